// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types, defaults and helpers for pipelined_magnitude_comparator
package cmp_pkg;

    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } cmp_res_t;

    localparam int SLICE_W_DEF = 4;
    localparam int CNT_W_DEF   = 16;

    function automatic int nslice(input int width, input int slice_w);
        return width / slice_w;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// cmp_slice: combinational SLICE_W-bit compare slice producing eq/gt.
//   i_a, i_b      : slice operands
//   i_msb_signed  : invert the top bit of both operands (sign slice in signed mode)
//   o_eq, o_gt    : slice equal / slice greater
module cmp_slice
    import cmp_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_msb_signed,
    output logic               o_eq,
    output logic               o_gt
);
    logic [SLICE_W-1:0] w_flip;
    logic [SLICE_W-1:0] w_a;
    logic [SLICE_W-1:0] w_b;

    // flipping the sign bit turns two's-complement order into unsigned order
    assign w_flip = SLICE_W'(i_msb_signed) << (SLICE_W - 1);
    assign w_a    = i_a ^ w_flip;
    assign w_b    = i_b ^ w_flip;
    assign o_eq   = (w_a == w_b);
    assign o_gt   = (w_a > w_b);

endmodule

// File: rtl/pipelined_magnitude_comparator.sv
// pipelined_magnitude_comparator: 2-stage valid/ready magnitude comparator (eq/lt/gt, signed or unsigned).
//   clk, reset_n            : clock, asynchronous active-low reset
//   in_valid/in_ready       : input handshake; a, b, cmp_signed travel together
//   out_valid/out_ready     : output handshake; eq, lt, gt one-hot while out_valid
//   cnt_clr, match_cnt      : saturating count of transferred eq results (only with CMP_MATCH_CNT_EN)
module pipelined_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = SLICE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cmp_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             lt,
    output logic             gt
`ifdef CMP_MATCH_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] match_cnt
`endif
);
    localparam int NSLICE = nslice(WIDTH, SLICE_W);

    if (WIDTH < SLICE_W || WIDTH % SLICE_W != 0 || CNT_W < 1) begin : g_bad_cfg
        $error("pipelined_magnitude_comparator: WIDTH must be a nonzero multiple of SLICE_W");
    end

    logic [NSLICE-1:0] w_slice_eq;
    logic [NSLICE-1:0] w_slice_gt;
    logic [NSLICE-1:0] r_s1_eq;
    logic [NSLICE-1:0] r_s1_gt;
    logic              r_s1_valid;
    logic              r_s2_valid;
    cmp_res_t          r_res;
    cmp_res_t          w_res;
    logic              w_gt;
    logic              w_s1_adv;
    logic              w_s2_adv;

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        cmp_slice #(.SLICE_W(SLICE_W)) u_slice (
            .i_a          (a[i*SLICE_W +: SLICE_W]),
            .i_b          (b[i*SLICE_W +: SLICE_W]),
            .i_msb_signed (i == NSLICE - 1 ? cmp_signed : 1'b0),
            .o_eq         (w_slice_eq[i]),
            .o_gt         (w_slice_gt[i])
        );
    end

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // scanning upward lets the most significant unequal slice decide gt
    always_comb begin
        w_gt = 1'b0;
        for (int i = 0; i < NSLICE; i++) w_gt = r_s1_eq[i] ? w_gt : r_s1_gt[i];
        w_res.eq = &r_s1_eq;
        w_res.gt = w_gt;
        w_res.lt = !w_res.eq && !w_gt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_eq    <= '0;
            r_s1_gt    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            r_s1_eq    <= in_valid ? w_slice_eq : r_s1_eq;
            r_s1_gt    <= in_valid ? w_slice_gt : r_s1_gt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_res      <= r_s1_valid ? w_res : r_res;
        end
    end

    assign out_valid = r_s2_valid;
    assign eq        = r_res.eq;
    assign lt        = r_res.lt;
    assign gt        = r_res.gt;

`ifdef CMP_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else if (cnt_clr) r_cnt <= '0;
        else if (out_valid && out_ready && r_res.eq && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_pipelined_magnitude_comparator.sv
// tb_pipelined_magnitude_comparator: scoreboard bench for pipelined_magnitude_comparator (CMP_MATCH_CNT_EN optional)
module tb_pipelined_magnitude_comparator;
    localparam int W  = 16;
    localparam int SW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cmp_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          eq, lt, gt;
`ifdef CMP_MATCH_CNT_EN
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] match_cnt;
    int            m_cnt = 0;
`endif

    int checks = 0;
    int failures = 0;
    int nres = 0;
    logic [2:0] exp_q[$];
    logic       hold_prev = 1'b0;
    logic [2:0] prev_res = '0;

    pipelined_magnitude_comparator #(.WIDTH(W), .SLICE_W(SW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cmp_signed (cmp_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .eq         (eq),
        .lt         (lt),
        .gt         (gt)
`ifdef CMP_MATCH_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .match_cnt  (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // {eq,lt,gt} straight from integer comparison of the operands
    function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic g, e;
        e = (x == y);
        g = s ? ($signed(x) > $signed(y)) : (x > y);
        return {e, !e && !g, g};
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
            chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
            chk("reset_res", {29'd0, eq, lt, gt}, 32'd0);
`ifdef CMP_MATCH_CNT_EN
            m_cnt = 0;
            chk("reset_match_cnt", {28'd0, match_cnt}, 32'd0);
`endif
        end else begin
`ifdef CMP_MATCH_CNT_EN
            chk("match_cnt", {28'd0, match_cnt}, m_cnt);
`endif
            if (out_valid) chk("onehot", $countones({eq, lt, gt}), 32'd1);
            if (out_valid && hold_prev) chk("hold_stable", {29'd0, eq, lt, gt}, {29'd0, prev_res});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_result actual=%b required=none", {eq, lt, gt});
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    chk("result", {29'd0, eq, lt, gt}, {29'd0, e});
`ifdef CMP_MATCH_CNT_EN
                    if (!cnt_clr && e[2] && m_cnt < 15) m_cnt++;
`endif
                end
                nres++;
            end
`ifdef CMP_MATCH_CNT_EN
            if (cnt_clr) m_cnt = 0;
`endif
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cmp_signed));
            hold_prev = out_valid && !out_ready;
            prev_res = {eq, lt, gt};
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        cmp_signed = s;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic s, input logic [2:0] req);
        send(x, y, s);
        @(negedge clk);
        chk({name, "_early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(name, {29'd0, eq, lt, gt}, {29'd0, req});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [0:7] pat;
        int base, first, last, cnt;
        pat = 8'b1001_0110;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        directed("u_eq", 16'h1234, 16'h1234, 1'b0, 3'b100);
        directed("u_gt", 16'h1235, 16'h1234, 1'b0, 3'b001);
        directed("u_lt", 16'h0FFF, 16'h1000, 1'b0, 3'b010);
        directed("s_lt", 16'h8000, 16'h0001, 1'b1, 3'b010);
        directed("s_as_u_gt", 16'h8000, 16'h0001, 1'b0, 3'b001);
        directed("s_gt", 16'hFFFF, 16'hFFFE, 1'b1, 3'b001);
        directed("s_lsb_gt", 16'h7F00, 16'h7EFF, 1'b1, 3'b001);
        drain();

        out_ready = 1'b0;
        send(16'h0001, 16'h0002, 1'b0);
        send(16'h0003, 16'h0003, 1'b0);
        @(negedge clk);
        chk("in_ready_full", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_release", {31'd0, in_ready}, 32'd1);
        drain();

        base = nres;
        fork
            for (int k = 0; k < 8; k++) send(W'($urandom), W'($urandom), 1'($urandom));
            begin
                for (int k = 0; k < 8; k++) begin
                    out_ready = pat[k];
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("bp_count", nres - base, 32'd8);

        base = nres;
        send(16'h0010, 16'h0020, 1'b0);
        send(16'h0020, 16'h0010, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk("reset_async_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_midreset", {31'd0, in_ready}, 32'd1);
        repeat (6) @(negedge clk);
        chk("no_stale_result", nres - base, 32'd0);
        @(posedge clk);
        #1;

        base = nres;
        first = -1;
        last = -1;
        cnt = 0;
        fork
            for (int k = 0; k < 100; k++) send(W'($urandom), (k % 7 == 0) ? a : W'($urandom), 1'(k % 3 == 0));
            for (int k = 0; k < 110; k++) begin
                @(negedge clk);
                if (out_valid) begin
                    if (first < 0) first = k;
                    last = k;
                    cnt++;
                end
            end
        join
        chk("tp_first_cycle", first, 32'd2);
        chk("tp_count", cnt, 32'd100);
        chk("tp_contiguous", last - first + 1, 32'd100);
        chk("tp_results", nres - base, 32'd100);
        drain();

`ifdef CMP_MATCH_CNT_EN
        @(posedge clk);
        #1 cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        for (int k = 0; k < 20; k++) send(W'(k * 3), W'(k * 3), 1'b0);
        drain();
        chk("cnt_saturate", {28'd0, match_cnt}, 32'd15);
        send(16'h5555, 16'h5555, 1'b0);
        @(posedge clk);
        #1 cnt_clr = 1'b1;
        @(negedge clk);
        chk("cnt_clr_with_eq_valid", {31'd0, out_valid && eq}, 32'd1);
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk("cnt_clr_priority", {28'd0, match_cnt}, 32'd0);
        drain();
`endif

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
